mc_main_control: RTL and testbench
==================================

Name: mc_main_control

Overview:
- Multi-cycle main control FSM for the MIPS-lite datapath.
- Sits directly upstream of the ALU control decoder and drives its aluop2/aluop1/aluop0 inputs.
- Sequences fetch, decode, execute, memory and writeback per instruction and generates all datapath enables and mux selects.
- Supports R-type, lw, sw, beq, j, nori and blezal, with a memory-ready wait handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch equal
- OP_J, 6'b000010, jump
- OP_NORI, 6'b001100, nor-immediate (zero-extended imm)
- OP_BLEZAL, 6'b000110, branch if rs<=0 and link $31

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  instruction opcode, from instruction register
- zero  in  1  ALU zero flag
- neg  in  1  ALU result sign bit
- mem_ready  in  1  memory completed access this cycle
- pcwrite  out  1  unconditional PC write
- pcwritecond  out  1  PC write if zero
- iord  out  1  memory address: 0=PC, 1=ALUOut
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- memtoreg  out  2  reg write data: 00=ALUOut, 01=MDR, 10=PC
- regdst  out  2  dest reg: 00=rt, 01=rd, 10=$31
- regwrite  out  1  register file write
- alusrca  out  1  ALU A: 0=PC, 1=rs
- alusrcb  out  2  ALU B: 00=rt, 01=4, 10=imm, 11=imm<<2
- zeroext  out  1  immediate zero-extended when 1
- pcsource  out  2  00=ALU, 01=ALUOut, 10=jump target
- aluop2, aluop1, aluop0  out  1 each  to ALU control
- state_o  out  4  current state, debug

Behaviour:
- Moore FSM; 4-bit state register. All outputs decode combinationally from state; only blezal enables also depend on zero/neg.
- Unlisted outputs are 0 in every state. aluop defaults to 000.
- Reset: rst_n low -> state=FETCH immediately; outputs equal FETCH decode; pcwrite/irwrite forced 0 while rst_n low.
- FETCH(0): memread=1, alusrcb=01, pcsource=00. irwrite and pcwrite asserted only when mem_ready=1. Stay in FETCH while mem_ready=0; on mem_ready=1 -> DECODE.
- DECODE(1): alusrcb=11, aluop=000 (branch target into ALUOut). Next by op:
  - lw/sw -> MEMADR
  - R -> REXEC
  - beq -> BEQ
  - j -> JUMP
  - nori -> NORIEX
  - blezal -> BLEZAL
  - other -> FETCH (no architectural effect)
- MEMADR(2): alusrca=1, alusrcb=10, aluop=000. lw -> MEMRD; sw -> MEMWR.
- MEMRD(3): memread=1, iord=1. Wait for mem_ready, then -> MEMWB.
- MEMWB(4): regwrite=1, memtoreg=01, regdst=00 -> FETCH.
- MEMWR(5): memwrite=1, iord=1. Wait for mem_ready, then -> FETCH. memwrite stays high through the wait.
- REXEC(6): alusrca=1, alusrcb=00, aluop=010 -> RWB.
- RWB(7): regwrite=1, regdst=01 -> FETCH.
- BEQ(8): alusrca=1, alusrcb=00, aluop=001, pcwritecond=1, pcsource=01 -> FETCH.
- JUMP(9): pcwrite=1, pcsource=10 -> FETCH.
- NORIEX(10): alusrca=1, alusrcb=10, zeroext=1, aluop=011 -> NORIWB.
- NORIWB(11): regwrite=1, regdst=00 -> FETCH.
- BLEZAL(12): alusrca=1, alusrcb=00, aluop=100.
  - c = zero|neg.
  - pcwrite=c, pcsource=01, regwrite=c, regdst=10, memtoreg=10.
  - -> FETCH.
- Encodings 13-15 unreachable; if entered, next state is FETCH.
- Cycle counts including fetch (mem_ready=1):
  - lw 5, sw 4, R 4, nori 4, beq/j/blezal 3.
  - Each mem_ready-low cycle adds one cycle.
- Reset asserted mid-instruction aborts it; no write strobe is asserted after rst_n falls.

Optional Feature:
- Macro MC_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal_op (1 bit, reset 0) and state TRAP(13).
  - DECODE with unknown op -> TRAP.
  - TRAP asserts illegal_op=1 with all strobes 0 and holds until reset.
- Undefined: no illegal_op port; unknown op returns to FETCH as described.

Test Plan:
- rst_n low during MEMRD -> state_o=0 immediately; after release, FETCH with mem_ready=1 gives irwrite=1, pcwrite=1 for one cycle.
- op=100011, mem_ready=1 always -> states 0,1,2,3,4,0; MEMWB shows regwrite=1, memtoreg=01; aluop=000 in state 2.
- op=000000 -> state 6 drives aluop2..0=010; state 7 gives regwrite=1, regdst=01.
- op=101011 with mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH.
- op=000110:
  - neg=1 -> pcwrite=1, regwrite=1, regdst=10, memtoreg=10, aluop=100.
  - zero=0, neg=0 -> pcwrite=0, regwrite=0.
- op=111111 -> returns to FETCH after DECODE. With MC_ILLEGAL_TRAP_EN -> state 13, illegal_op=1 held until rst_n low.

Source files
------------

// File: rtl/mc_main_control_if.sv
// rtl/mc_main_control_if.sv - control bus between the main FSM and the MIPS-lite datapath
// Purpose: bundles the datapath status inputs and every enable/select the
//          main control FSM drives.
// Modports:
//   master - controller side: receives op/zero/neg/mem_ready, drives strobes/selects
//   slave  - datapath side: drives op/zero/neg/mem_ready, receives strobes/selects
interface mc_main_control_if;
    logic [5:0] op;
    logic       zero;
    logic       neg;
    logic       mem_ready;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] memtoreg;
    logic [1:0] regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsource;
    logic       aluop2;
    logic       aluop1;
    logic       aluop0;

    modport master (
        input  op, zero, neg, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, zeroext,
               pcsource, aluop2, aluop1, aluop0
    );

    modport slave (
        output op, zero, neg, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, zeroext,
               pcsource, aluop2, aluop1, aluop0
    );
endinterface

// File: rtl/mc_main_control.sv
// rtl/mc_main_control.sv - multi-cycle main control FSM for the MIPS-lite datapath
// Purpose: sequences fetch/decode/execute/memory/writeback for R-type, lw, sw,
//          beq, j, nori and blezal, with a memory-ready wait handshake.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset (state returns to FETCH at once)
//   ctl        - mc_main_control_if.master: op/zero/neg/mem_ready in, all
//                datapath enables, mux selects and aluop2..0 out
//   state_o    - current state, debug
//   illegal_op - (only with MC_ILLEGAL_TRAP_EN) high while trapped on an unknown opcode
// Optional feature: define MC_ILLEGAL_TRAP_EN to send unknown opcodes to a
//          TRAP state that holds until reset instead of returning to FETCH.
module mc_main_control (
    input  logic                 clk,
    input  logic                 rst_n,
    mc_main_control_if.master    ctl,
    output logic [3:0]           state_o
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    output logic                 illegal_op
`endif
);

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_NORI   = 6'b001100;
    localparam logic [5:0] OP_BLEZAL = 6'b000110;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_NORIEX = 4'd10,
        S_NORIWB = 4'd11,
        S_BLEZAL = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] aluop;
    logic       blez_c;

    // blezal takes the branch (and links) when rs <= 0, i.e. ALU sees zero or negative
    assign blez_c = ctl.zero | ctl.neg;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = ctl.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (ctl.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_REXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_NORI:      state_d = S_NORIEX;
                    OP_BLEZAL:    state_d = S_BLEZAL;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_d = (ctl.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = ctl.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = ctl.mem_ready ? S_FETCH : S_MEMWR;
            S_REXEC:  state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_NORIEX: state_d = S_NORIWB;
            S_NORIWB: state_d = S_FETCH;
            S_BLEZAL: state_d = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode; FETCH strobes wait on mem_ready, BLEZAL strobes on zero/neg.
    always_comb begin
        ctl.pcwrite     = 1'b0;
        ctl.pcwritecond = 1'b0;
        ctl.iord        = 1'b0;
        ctl.memread     = 1'b0;
        ctl.memwrite    = 1'b0;
        ctl.irwrite     = 1'b0;
        ctl.memtoreg    = 2'b00;
        ctl.regdst      = 2'b00;
        ctl.regwrite    = 1'b0;
        ctl.alusrca     = 1'b0;
        ctl.alusrcb     = 2'b00;
        ctl.zeroext     = 1'b0;
        ctl.pcsource    = 2'b00;
        aluop           = 3'b000;
        case (state_q)
            S_FETCH: begin
                ctl.memread  = 1'b1;
                ctl.alusrcb  = 2'b01;
                // PC/IR loads are held off while reset is asserted
                ctl.irwrite  = ctl.mem_ready & rst_n;
                ctl.pcwrite  = ctl.mem_ready & rst_n;
            end
            S_DECODE: begin
                ctl.alusrcb  = 2'b11;
            end
            S_MEMADR: begin
                ctl.alusrca  = 1'b1;
                ctl.alusrcb  = 2'b10;
            end
            S_MEMRD: begin
                ctl.memread  = 1'b1;
                ctl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctl.regwrite = 1'b1;
                ctl.memtoreg = 2'b01;
            end
            S_MEMWR: begin
                ctl.memwrite = 1'b1;
                ctl.iord     = 1'b1;
            end
            S_REXEC: begin
                ctl.alusrca  = 1'b1;
                aluop        = 3'b010;
            end
            S_RWB: begin
                ctl.regwrite = 1'b1;
                ctl.regdst   = 2'b01;
            end
            S_BEQ: begin
                ctl.alusrca     = 1'b1;
                aluop           = 3'b001;
                ctl.pcwritecond = 1'b1;
                ctl.pcsource    = 2'b01;
            end
            S_JUMP: begin
                ctl.pcwrite  = 1'b1;
                ctl.pcsource = 2'b10;
            end
            S_NORIEX: begin
                ctl.alusrca  = 1'b1;
                ctl.alusrcb  = 2'b10;
                ctl.zeroext  = 1'b1;
                aluop        = 3'b011;
            end
            S_NORIWB: begin
                ctl.regwrite = 1'b1;
            end
            S_BLEZAL: begin
                ctl.alusrca  = 1'b1;
                aluop        = 3'b100;
                ctl.pcwrite  = blez_c;
                ctl.pcsource = 2'b01;
                ctl.regwrite = blez_c;
                ctl.regdst   = 2'b10;
                ctl.memtoreg = 2'b10;
            end
            default: begin
            end
        endcase
    end

    assign ctl.aluop2 = aluop[2];
    assign ctl.aluop1 = aluop[1];
    assign ctl.aluop0 = aluop[0];
    assign state_o    = state_q;

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_op = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_main_control.sv
// tb/tb_mc_main_control.sv - self-checking bench for mc_main_control
module tb_mc_main_control;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3,
                   ST_MEMWB = 4, ST_MEMWR = 5, ST_REXEC = 6, ST_RWB = 7,
                   ST_BEQ = 8, ST_JUMP = 9, ST_NORIEX = 10, ST_NORIWB = 11,
                   ST_BLEZAL = 12, ST_TRAP = 13;

    logic       clk;
    logic       rst_n;
    logic [3:0] state_o;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    mc_main_control_if ctl ();

    mc_main_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctl        (ctl),
        .state_o    (state_o)
`ifdef MC_ILLEGAL_TRAP_EN
        ,
        .illegal_op (illegal_op)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] legal_ops [7];
    logic [5:0] bad_ops   [3];

    // Control word order: pcwrite pcwritecond iord memread memwrite irwrite
    // memtoreg[2] regdst[2] regwrite alusrca alusrcb[2] zeroext pcsource[2] aluop[3]
    function automatic logic [19:0] dut_cw();
        return {ctl.pcwrite, ctl.pcwritecond, ctl.iord, ctl.memread, ctl.memwrite,
                ctl.irwrite, ctl.memtoreg, ctl.regdst, ctl.regwrite, ctl.alusrca,
                ctl.alusrcb, ctl.zeroext, ctl.pcsource, ctl.aluop2, ctl.aluop1, ctl.aluop0};
    endfunction

    // Reference: what each step of the instruction flow must drive.
    function automatic logic [19:0] exp_cw(int st, bit mr, bit c);
        bit pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0, rw = 0, asa = 0, zx = 0;
        bit [1:0] mtr = 0, rd = 0, asb = 0, ps = 0;
        bit [2:0] aop = 0;
        case (st)
            ST_FETCH:  begin mrd = 1; asb = 1; irw = mr; pw = mr; end
            ST_DECODE: asb = 3;
            ST_MEMADR: begin asa = 1; asb = 2; end
            ST_MEMRD:  begin mrd = 1; io = 1; end
            ST_MEMWB:  begin rw = 1; mtr = 1; end
            ST_MEMWR:  begin mwr = 1; io = 1; end
            ST_REXEC:  begin asa = 1; aop = 2; end
            ST_RWB:    begin rw = 1; rd = 1; end
            ST_BEQ:    begin asa = 1; aop = 1; pwc = 1; ps = 1; end
            ST_JUMP:   begin pw = 1; ps = 2; end
            ST_NORIEX: begin asa = 1; asb = 2; zx = 1; aop = 3; end
            ST_NORIWB: rw = 1;
            ST_BLEZAL: begin asa = 1; aop = 4; pw = c; ps = 1; rw = c; rd = 2; mtr = 2; end
            default:   ;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, mtr, rd, rw, asa, asb, zx, ps, aop};
    endfunction

    task automatic check(string tag, logic [19:0] obs, logic [19:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs just after the edge, check at the falling edge.
    task automatic run_cycle(int st, bit mr, bit z, bit n);
        ctl.mem_ready = mr;
        ctl.zero      = z;
        ctl.neg       = n;
        @(negedge clk);
        check($sformatf("state(op=%h)", ctl.op), {16'd0, state_o}, st[19:0]);
        check($sformatf("ctl(st=%0d mr=%0d z=%0d n=%0d)", st, mr, z, n),
              dut_cw(), exp_cw(st, mr, z | n));
`ifdef MC_ILLEGAL_TRAP_EN
        check("illegal_op", {19'd0, illegal_op}, {19'd0, st == ST_TRAP});
`endif
        @(posedge clk);
        #1;
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Full instruction: fetch (with fw stall cycles), decode, then the op's flow.
    task automatic run_instr(logic [5:0] opc, int fw, int mw, bit z, bit n);
        ctl.op = opc;
        for (int i = 0; i < fw; i++) run_cycle(ST_FETCH, 1'b0, rb(), rb());
        run_cycle(ST_FETCH, 1'b1, rb(), rb());
        run_cycle(ST_DECODE, rb(), rb(), rb());
        case (opc)
            6'b100011: begin
                run_cycle(ST_MEMADR, rb(), rb(), rb());
                for (int i = 0; i < mw; i++) run_cycle(ST_MEMRD, 1'b0, rb(), rb());
                run_cycle(ST_MEMRD, 1'b1, rb(), rb());
                run_cycle(ST_MEMWB, rb(), rb(), rb());
            end
            6'b101011: begin
                run_cycle(ST_MEMADR, rb(), rb(), rb());
                for (int i = 0; i < mw; i++) run_cycle(ST_MEMWR, 1'b0, rb(), rb());
                run_cycle(ST_MEMWR, 1'b1, rb(), rb());
            end
            6'b000000: begin
                run_cycle(ST_REXEC, rb(), rb(), rb());
                run_cycle(ST_RWB, rb(), rb(), rb());
            end
            6'b000100: run_cycle(ST_BEQ, rb(), z, n);
            6'b000010: run_cycle(ST_JUMP, rb(), rb(), rb());
            6'b001100: begin
                run_cycle(ST_NORIEX, rb(), rb(), rb());
                run_cycle(ST_NORIWB, rb(), rb(), rb());
            end
            6'b000110: run_cycle(ST_BLEZAL, rb(), z, n);
            default: ;
        endcase
    endtask

    initial begin
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b000010, 6'b001100, 6'b000110};
        bad_ops   = '{6'b111111, 6'b000001, 6'b001101};

        rst_n         = 1'b0;
        ctl.op        = 6'b100011;
        ctl.zero      = 1'b0;
        ctl.neg       = 1'b0;
        ctl.mem_ready = 1'b1;
        #2;
        // In reset with mem_ready=1: FETCH decode but PC/IR loads suppressed
        check("reset_state", {16'd0, state_o}, 20'd0);
        check("reset_ctl", dut_cw(), exp_cw(ST_FETCH, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed flows
        run_instr(6'b100011, 0, 0, 0, 0);
        run_instr(6'b000000, 0, 0, 0, 0);
        run_instr(6'b101011, 0, 3, 0, 0);
        run_instr(6'b000110, 0, 0, 0, 1);
        run_instr(6'b000110, 0, 0, 0, 0);
        run_instr(6'b000110, 1, 0, 1, 0);
        run_instr(6'b001100, 2, 0, 0, 0);
        run_instr(6'b000100, 0, 0, 1, 0);
        run_instr(6'b000010, 0, 0, 0, 0);

        // Randomized instruction stream
        for (int k = 0; k < 60; k++) begin
            logic [5:0] opc;
            opc = legal_ops[$urandom_range(0, 6)];
`ifndef MC_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) opc = bad_ops[$urandom_range(0, 2)];
`endif
            run_instr(opc, $urandom_range(0, 2), $urandom_range(0, 3), rb(), rb());
        end

        // Reset in the middle of a load's memory read
        ctl.op = 6'b100011;
        run_cycle(ST_FETCH, 1'b1, 0, 0);
        run_cycle(ST_DECODE, 1'b1, 0, 0);
        run_cycle(ST_MEMADR, 1'b1, 0, 0);
        run_cycle(ST_MEMRD, 1'b0, 0, 0);
        ctl.mem_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_state", {16'd0, state_o}, 20'd0);
        check("midreset_ctl", dut_cw(), exp_cw(ST_FETCH, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check("midreset_hold", dut_cw(), exp_cw(ST_FETCH, 1'b0, 1'b0));
        rst_n = 1'b1;
        run_cycle(ST_FETCH, 1'b1, 0, 0);
        run_cycle(ST_DECODE, 1'b1, 0, 0);
        run_cycle(ST_MEMADR, 1'b1, 0, 0);
        run_cycle(ST_MEMRD, 1'b1, 0, 0);
        run_cycle(ST_MEMWB, 1'b1, 0, 0);

        // Unknown opcode
        run_instr(6'b111111, 0, 0, 0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) run_cycle(ST_TRAP, rb(), rb(), rb());
        rst_n = 1'b0;
        #1;
        check("trap_reset_state", {16'd0, state_o}, 20'd0);
        check("trap_reset_illegal", {19'd0, illegal_op}, 20'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`endif
        run_cycle(ST_FETCH, 1'b1, 0, 0);
        run_cycle(ST_DECODE, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
